// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game lane logic.
package rhythm_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2
    } lane_state_t;

    localparam logic [7:0] KEY_START     = 8'h2C;
    localparam logic [7:0] KEY_RESTART   = 8'h01;
    localparam int         ARROW_H       = 40;
    localparam int         PERF_PTS_DFLT = 2;
    localparam int         GOOD_PTS_DFLT = 1;

endpackage

// File: rtl/hit_window_classify.sv
// Combinational grading of one note's bottom edge against the hit windows.
module hit_window_classify
    import rhythm_pkg::*;
#(
    parameter int GOOD_LO = 340,
    parameter int PERF_LO = 360,
    parameter int PERF_HI = 380,
    parameter int Y_MAX   = 400
) (
    input  logic [9:0] y_i,
    output logic       in_good_o,
    output logic       in_perf_o,
    output logic       is_miss_o
);

    logic [10:0] bottom;

    // 11-bit bottom edge so Y + ARROW_H never wraps
    assign bottom    = {1'b0, y_i} + 11'(ARROW_H);
    assign in_good_o = (bottom >= 11'(GOOD_LO)) && (bottom < 11'(Y_MAX));
    assign in_perf_o = (bottom >= 11'(PERF_LO)) && (bottom < 11'(PERF_HI));
    assign is_miss_o = (bottom >= 11'(Y_MAX));

endmodule

// File: rtl/note_lane_dropper.sv
// One rhythm-game lane: multi-slot falling notes, key grading, score and combo.
module note_lane_dropper
    import rhythm_pkg::*;
#(
    parameter logic [7:0] LANE_KEY = 8'h4F,
    parameter int         SLOTS    = 4,
    parameter int         X_POS    = 500,
    parameter int         Y_START  = 100,
    parameter int         Y_MAX    = 400,
    parameter int         SPEED    = 1,
    parameter int         GOOD_LO  = 340,
    parameter int         PERF_LO  = 360,
    parameter int         PERF_HI  = 380,
    parameter int         SCORE_W  = 16,
    parameter int         PERF_PTS = PERF_PTS_DFLT,
    parameter int         GOOD_PTS = GOOD_PTS_DFLT
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [7:0]            keycode,
    input  logic [7:0]            keycode_second,
    input  logic                  spawn_valid,
    output logic                  spawn_ready,
    input  logic                  song_done,
    output logic [9:0]            laneX,
    output logic [SLOTS*10-1:0]   noteY,
    output logic [SLOTS-1:0]      note_valid,
    output logic                  hit_perfect,
    output logic                  hit_good,
    output logic                  miss,
    output logic [SCORE_W-1:0]    score,
    output logic [9:0]            combo,
    output logic [1:0]            lane_state
);

    localparam logic [9:0]         SPEED_V   = 10'(SPEED);
    localparam logic [9:0]         Y_START_V = 10'(Y_START);
    localparam logic [SCORE_W-1:0] PERF_ADD  = SCORE_W'(PERF_PTS);
    localparam logic [SCORE_W-1:0] GOOD_ADD  = SCORE_W'(GOOD_PTS);

    lane_state_t        state_q, state_d;
    logic [9:0]         y_q [SLOTS];
    logic [9:0]         y_d [SLOTS];
    logic [SLOTS-1:0]   vld_q, vld_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [9:0]         combo_q, combo_d;
    logic               key_q, key_d;
    logic               perf_q, perf_d, good_q, good_d, miss_q, miss_d;

    logic [SLOTS-1:0]   in_good, in_perf, is_miss;
    logic [SLOTS-1:0]   tgt_oh, free_oh;
    logic [9:0]         tgt_y;
    logic               tgt_found, pressed, strike, hit, miss_any;

    function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] a,
                                                         input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        hit_window_classify #(
            .GOOD_LO(GOOD_LO), .PERF_LO(PERF_LO), .PERF_HI(PERF_HI), .Y_MAX(Y_MAX)
        ) u_cls (
            .y_i      (y_q[g]),
            .in_good_o(in_good[g]),
            .in_perf_o(in_perf[g]),
            .is_miss_o(is_miss[g])
        );
        assign noteY[10*g +: 10] = y_q[g];
    end

    assign pressed     = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);
    assign strike      = pressed && !key_q;
    assign hit         = strike && tgt_found;
    assign miss_any    = |(vld_q & is_miss);
    assign spawn_ready = (state_q == RUN) && !(&vld_q);
    assign laneX       = 10'(X_POS);
    assign note_valid  = vld_q;
    assign hit_perfect = perf_q;
    assign hit_good    = good_q;
    assign miss        = miss_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign lane_state  = state_q;

    // Target is the lowest note in the good window; strict > keeps the lowest index on ties
    always_comb begin
        tgt_oh    = '0;
        tgt_y     = '0;
        tgt_found = 1'b0;
        free_oh   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (vld_q[i] && in_good[i] && (!tgt_found || y_q[i] > tgt_y)) begin
                tgt_oh    = '0;
                tgt_oh[i] = 1'b1;
                tgt_y     = y_q[i];
                tgt_found = 1'b1;
            end
            if (!vld_q[i] && (free_oh == '0)) free_oh[i] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        y_d     = y_q;
        score_d = score_q;
        combo_d = combo_q;
        key_d   = pressed;
        perf_d  = 1'b0;
        good_d  = 1'b0;
        miss_d  = 1'b0;
        case (state_q)
            HALTED: begin
                if (keycode == KEY_START) begin
                    state_d = RUN;
                    score_d = '0;
                    combo_d = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (vld_q[i]) begin
                        if (hit && tgt_oh[i]) vld_d[i] = 1'b0;
                        else if (is_miss[i]) vld_d[i] = 1'b0;
                        else y_d[i] = y_q[i] + SPEED_V;
                    end
                end
                // Spawn uses the registered free map, so a slot freed now waits one frame
                if (spawn_valid && spawn_ready) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (free_oh[i]) begin
                            vld_d[i] = 1'b1;
                            y_d[i]   = Y_START_V;
                        end
                    end
                end
                if (hit) begin
                    perf_d  = |(tgt_oh & in_perf);
                    good_d  = !(|(tgt_oh & in_perf));
                    score_d = sat_add_score(score_q, perf_d ? PERF_ADD : GOOD_ADD);
                end
                miss_d = miss_any;
                if (miss_any) combo_d = '0;
                else if (hit && combo_q != 10'h3FF) combo_d = combo_q + 10'd1;
                if (song_done && (vld_q == '0)) state_d = DONE;
            end
            DONE: begin
                if (keycode == KEY_RESTART) state_d = HALTED;
            end
            default: state_d = HALTED;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= HALTED;
            vld_q   <= '0;
            score_q <= '0;
            combo_q <= '0;
            key_q   <= 1'b0;
            perf_q  <= 1'b0;
            good_q  <= 1'b0;
            miss_q  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) y_q[i] <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            score_q <= score_d;
            combo_q <= combo_d;
            key_q   <= key_d;
            perf_q  <= perf_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            for (int i = 0; i < SLOTS; i++) y_q[i] <= y_d[i];
        end
    end

endmodule

// File: tb/tb_note_lane_dropper.sv
// Scoreboard bench: a frame-level lane model predicts every output frame; a monitor compares.
module tb_note_lane_dropper;

    localparam int         SLOTS    = 4;
    localparam logic [7:0] LANE_KEY = 8'h4F;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [7:0]  keycode, keycode_second;
    logic        spawn_valid, spawn_ready, song_done;
    logic [9:0]  laneX;
    logic [39:0] noteY;
    logic [3:0]  note_valid;
    logic        hit_perfect, hit_good, miss;
    logic [15:0] score;
    logic [9:0]  combo;
    logic [1:0]  lane_state;

    always #5 frame_clk = ~frame_clk;

    note_lane_dropper dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycode       (keycode),
        .keycode_second(keycode_second),
        .spawn_valid   (spawn_valid),
        .spawn_ready   (spawn_ready),
        .song_done     (song_done),
        .laneX         (laneX),
        .noteY         (noteY),
        .note_valid    (note_valid),
        .hit_perfect   (hit_perfect),
        .hit_good      (hit_good),
        .miss          (miss),
        .score         (score),
        .combo         (combo),
        .lane_state    (lane_state)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          st;
        logic [3:0]  v;
        logic [39:0] ny;
        int          sc;
        int          cb;
        bit          hp, hg, ms, rst;
    } snap_t;

    snap_t sbq[$];

    // Reference lane: note positions as plain integers, one update per frame
    int m_st, m_sc, m_cb;
    int m_y[SLOTS];
    bit m_v[SLOTS];
    bit m_key;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge frame_clk) begin : model
        snap_t s;
        bit    pressed, strike, hit, empty, hp, hg, ms;
        int    t, f;
        hp = 0; hg = 0; ms = 0;
        if (Reset === 1'b1) begin
            m_st = 0; m_sc = 0; m_cb = 0; m_key = 0;
            for (int i = 0; i < SLOTS; i++) begin m_y[i] = 0; m_v[i] = 0; end
        end else begin
            pressed = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);
            strike  = pressed && !m_key;
            m_key   = pressed;
            if (m_st == 0) begin
                if (keycode == 8'h2C) begin m_st = 1; m_sc = 0; m_cb = 0; end
            end else if (m_st == 1) begin
                empty = 1; f = -1; t = -1;
                for (int i = 0; i < SLOTS; i++) begin
                    if (m_v[i]) empty = 0;
                    else if (f < 0) f = i;
                    if (m_v[i] && m_y[i] + 40 >= 340 && m_y[i] + 40 < 400 &&
                        (t < 0 || m_y[i] > m_y[t])) t = i;
                end
                hit = strike && (t >= 0);
                if (hit) begin
                    if (m_y[t] + 40 >= 360 && m_y[t] + 40 < 380) begin hp = 1; m_sc += 2; end
                    else begin hg = 1; m_sc += 1; end
                    if (m_sc > 65535) m_sc = 65535;
                    m_v[t] = 0;
                end
                for (int i = 0; i < SLOTS; i++) begin
                    if (m_v[i]) begin
                        if (m_y[i] + 40 >= 400) begin m_v[i] = 0; ms = 1; end
                        else m_y[i] += 1;
                    end
                end
                if (spawn_valid && f >= 0) begin m_v[f] = 1; m_y[f] = 100; end
                if (ms) m_cb = 0;
                else if (hit && m_cb < 1023) m_cb += 1;
                if (song_done && empty) m_st = 2;
            end else begin
                if (keycode == 8'h01) m_st = 0;
            end
        end
        s.st = m_st; s.sc = m_sc; s.cb = m_cb;
        s.hp = hp; s.hg = hg; s.ms = ms; s.rst = (Reset === 1'b1);
        for (int i = 0; i < SLOTS; i++) begin
            s.v[i]         = m_v[i];
            s.ny[10*i +: 10] = 10'(m_y[i]);
        end
        sbq.push_back(s);
    end

    always @(negedge frame_clk) begin : monitor
        snap_t       e;
        logic [39:0] mask;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            mask = '0;
            for (int i = 0; i < SLOTS; i++) if (e.v[i] || e.rst) mask[10*i +: 10] = 10'h3FF;
            chk("lane_state", 64'(lane_state), 64'(e.st));
            chk("note_valid", 64'(note_valid), 64'(e.v));
            chk("noteY", 64'(noteY & mask), 64'(e.ny & mask));
            chk("score", 64'(score), 64'(e.sc));
            chk("combo", 64'(combo), 64'(e.cb));
            chk("hit_perfect", 64'(hit_perfect), 64'(e.hp));
            chk("hit_good", 64'(hit_good), 64'(e.hg));
            chk("miss", 64'(miss), 64'(e.ms));
            chk("spawn_ready", 64'(spawn_ready), 64'((e.st == 1) && (e.v != 4'hF)));
            chk("laneX", 64'(laneX), 64'd500);
        end
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic spawn1();
        spawn_valid = 1'b1;
        tick();
        spawn_valid = 1'b0;
    endtask

    task automatic press_once(input bit second);
        if (second) keycode_second = LANE_KEY;
        else keycode = LANE_KEY;
        tick();
        keycode = 8'h00;
        keycode_second = 8'h00;
    endtask

    function automatic logic [7:0] pick_key();
        int r;
        r = $urandom_range(0, 15);
        if (r < 10) return 8'h00;
        if (r < 12) return LANE_KEY;
        if (r == 12) return 8'h2C;
        if (r == 13) return 8'h01;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        Reset = 1'b1; keycode = 8'h00; keycode_second = 8'h00;
        spawn_valid = 1'b0; song_done = 1'b0;
        idle(3);
        Reset = 1'b0;
        keycode = 8'h2C; tick(); keycode = 8'h00;
        // reset with two live notes discards them silently
        spawn1(); spawn1(); idle(5);
        Reset = 1'b1; tick(); Reset = 1'b0; idle(2);
        keycode = 8'h2C; tick(); keycode = 8'h00;
        // untouched note falls and misses
        spawn1(); idle(265);
        // perfect via second keycode, then good
        spawn1(); idle(230); press_once(1'b1); idle(5);
        spawn1(); idle(205); press_once(1'b0); idle(5);
        // early strike does nothing; held key hits once
        spawn1(); idle(100); press_once(1'b0); idle(99);
        keycode = LANE_KEY; idle(30); keycode = 8'h00; idle(80);
        // fill every slot; extra spawn requests are ignored
        spawn_valid = 1'b1; idle(6); spawn_valid = 1'b0;
        idle(200); press_once(1'b0); idle(300);
        // miss and perfect hit on the same frame
        spawn1(); idle(29); spawn1(); idle(230); press_once(1'b0); idle(100);
        song_done = 1'b1; tick(); song_done = 1'b0; idle(2);
        keycode = 8'h01; tick(); keycode = 8'h00; idle(2);
        keycode = 8'h2C; tick(); keycode = 8'h00;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 400; i++) begin
                keycode        = pick_key();
                keycode_second = pick_key();
                spawn_valid    = (c % 2 == 0) && ($urandom_range(0, 9) == 0);
                song_done      = (c % 2 == 1) && ($urandom_range(0, 19) == 0);
                Reset          = ($urandom_range(0, 799) == 0);
                tick();
            end
        end
        Reset = 1'b0; keycode = 8'h00; keycode_second = 8'h00;
        spawn_valid = 1'b0; song_done = 1'b0;
        idle(3);
        @(negedge frame_clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
